// File: rtl/udp_tx_stream_arbiter.sv
// rtl/udp_tx_stream_arbiter.sv - packet-level round-robin arbiter for the UDP TX user input
//
// Shares one registered AXI-Stream output among NUM_PORTS user streams. A grant
// is held from the first accepted beat through the accepted tlast beat, so
// packets are never interleaved. Each beat carries its port's connection id.
//
// Ports:
//   tx_axis_aclk / tx_axis_aresetn  clock, asynchronous active-low reset
//   port_enable                     per-port enable, only looked at during arbitration
//   s_axis_*                        NUM_PORTS packed user streams (tvalid/tready/tdata/tkeep/tlast/connection_id)
//   m_axis_*                        registered output stream towards the TX engine
//   busy                            high while a packet grant is held
//   grant_idx                       currently or most recently granted port
module udp_tx_stream_arbiter #(
  parameter  int NUM_PORTS      = 4,
  parameter  int DATA_WIDTH     = 512,
  parameter  int CONN_ID_WIDTH  = 18,
  localparam int PORT_IDX_WIDTH = $clog2(NUM_PORTS),
  localparam int KEEP_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                               tx_axis_aclk,
  input  logic                               tx_axis_aresetn,
  input  logic [NUM_PORTS-1:0]               port_enable,
  input  logic [NUM_PORTS-1:0]               s_axis_tvalid,
  output logic [NUM_PORTS-1:0]               s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]               s_axis_tlast,
  input  logic [NUM_PORTS*CONN_ID_WIDTH-1:0] s_axis_connection_id,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]              m_axis_tkeep,
  output logic                               m_axis_tlast,
  output logic [CONN_ID_WIDTH-1:0]           m_axis_connection_id,
  output logic                               busy,
  output logic [PORT_IDX_WIDTH-1:0]          grant_idx
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                    state;
  logic [NUM_PORTS-1:0]      req;
  logic                      found;
  logic [PORT_IDX_WIDTH-1:0] winner;
  logic [PORT_IDX_WIDTH-1:0] cand;
  logic                      out_free;
  logic                      accept;

  assign req      = s_axis_tvalid & port_enable;
  assign busy     = (state == ST_BUSY);
  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = !m_axis_tvalid || m_axis_tready;

  // grant_idx doubles as last_grant: the search starts one past it and wraps.
  // The modulo keeps candidates below NUM_PORTS for non-power-of-2 port counts.
  always_comb begin
    found  = 1'b0;
    winner = grant_idx;
    cand   = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = PORT_IDX_WIDTH'((int'(grant_idx) + off) % NUM_PORTS);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (busy && out_free) begin
      s_axis_tready = NUM_PORTS'(1) << grant_idx;
    end
  end

  assign accept = busy && out_free && s_axis_tvalid[grant_idx];

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      state                <= ST_IDLE;
      grant_idx            <= PORT_IDX_WIDTH'(NUM_PORTS - 1);
      m_axis_tvalid        <= 1'b0;
      m_axis_tdata         <= '0;
      m_axis_tkeep         <= '0;
      m_axis_tlast         <= 1'b0;
      m_axis_connection_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant_idx <= winner;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && s_axis_tlast[grant_idx]) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A load and a drain in the same cycle simply replace the held beat.
      if (accept) begin
        m_axis_tvalid        <= 1'b1;
        m_axis_tdata         <= s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep         <= s_axis_tkeep[grant_idx*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tlast         <= s_axis_tlast[grant_idx];
        m_axis_connection_id <= s_axis_connection_id[grant_idx*CONN_ID_WIDTH +: CONN_ID_WIDTH];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_stream_arbiter.sv
// tb/tb_udp_tx_stream_arbiter.sv - self-checking bench for udp_tx_stream_arbiter
module tb_udp_tx_stream_arbiter;

  localparam int NP = 4;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int CW = 18;

  logic              clk;
  logic              rst_n;
  logic [NP-1:0]     port_enable;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tready;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP-1:0]     s_tlast;
  logic [NP*CW-1:0]  s_conn;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [CW-1:0]     m_conn;
  logic              busy;
  logic [1:0]        grant_idx;

  udp_tx_stream_arbiter #(
    .NUM_PORTS    (NP),
    .DATA_WIDTH   (DW),
    .CONN_ID_WIDTH(CW)
  ) dut (
    .tx_axis_aclk        (clk),
    .tx_axis_aresetn     (rst_n),
    .port_enable         (port_enable),
    .s_axis_tvalid       (s_tvalid),
    .s_axis_tready       (s_tready),
    .s_axis_tdata        (s_tdata),
    .s_axis_tkeep        (s_tkeep),
    .s_axis_tlast        (s_tlast),
    .s_axis_connection_id(s_conn),
    .m_axis_tvalid       (m_tvalid),
    .m_axis_tready       (m_tready),
    .m_axis_tdata        (m_tdata),
    .m_axis_tkeep        (m_tkeep),
    .m_axis_tlast        (m_tlast),
    .m_axis_connection_id(m_conn),
    .busy                (busy),
    .grant_idx           (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic [3:0] vld;
    logic [3:0] last;
    int         beat;
    logic       mrdy;
    logic [3:0] e_srdy;
    logic       e_mvld;
    logic       e_mlast;
    int         e_port;
    int         e_beat;
    logic       e_busy;
    logic [1:0] e_gidx;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   sb_q[$];
  logic sb_on = 1'b0;

  function automatic logic [DW-1:0] dat(int p, int b);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) begin
      r[i*32 +: 32] = 32'hA500_0000 | 32'(i << 16) | 32'(p << 8) | 32'(b);
    end
    return r;
  endfunction

  function automatic logic [KW-1:0] kp(int p, int b);
    return {56'hFF_FFFF_FFFF_FFFF, 8'(p * 16 + b)};
  endfunction

  function automatic logic [CW-1:0] cid(int p);
    return CW'(5 + p * 4096);
  endfunction

  function automatic logic [3:0] oh(int p);
    return 4'(1 << p);
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic drive(logic [3:0] en, logic [3:0] vld, logic [3:0] last, int beat, logic mrdy);
    port_enable = en;
    s_tvalid    = vld;
    s_tlast     = last;
    m_tready    = mrdy;
    for (int p = 0; p < NP; p++) begin
      s_tdata[p*DW +: DW] = dat(p, beat);
      s_tkeep[p*KW +: KW] = kp(p, beat);
      s_conn[p*CW +: CW]  = cid(p);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic add(logic rst, logic [3:0] en, logic [3:0] vld, logic [3:0] last, int beat,
                     logic mrdy, logic [3:0] srdy, logic mvld, logic mlast, int mport,
                     int mbeat, logic bsy, logic [1:0] gidx);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.last = last; v.beat = beat; v.mrdy = mrdy;
    v.e_srdy = srdy; v.e_mvld = mvld; v.e_mlast = mlast; v.e_port = mport;
    v.e_beat = mbeat; v.e_busy = bsy; v.e_gidx = gidx;
    vq.push_back(v);
  endtask

  task automatic run_table(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      if (vq[i].rst) do_reset();
      drive(vq[i].en, vq[i].vld, vq[i].last, vq[i].beat, vq[i].mrdy);
      @(negedge clk);
      chk($sformatf("v%0d s_tready", i), DW'(s_tready), DW'(vq[i].e_srdy));
      chk($sformatf("v%0d m_tvalid", i), DW'(m_tvalid), DW'(vq[i].e_mvld));
      chk($sformatf("v%0d busy", i), DW'(busy), DW'(vq[i].e_busy));
      chk($sformatf("v%0d grant_idx", i), DW'(grant_idx), DW'(vq[i].e_gidx));
      if (vq[i].e_mvld) begin
        chk($sformatf("v%0d m_tlast", i), DW'(m_tlast), DW'(vq[i].e_mlast));
        chk($sformatf("v%0d m_tdata", i), m_tdata, dat(vq[i].e_port, vq[i].e_beat));
        chk($sformatf("v%0d m_tkeep", i), DW'(m_tkeep), DW'(kp(vq[i].e_port, vq[i].e_beat)));
        chk($sformatf("v%0d m_conn", i), DW'(m_conn), DW'(cid(vq[i].e_port)));
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Every output transfer while enabled must be the next expected port-2 beat.
  always @(negedge clk) begin
    if (sb_on && m_tvalid && m_tready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: got beat %0h expected none", m_tdata[7:0]);
      end else begin
        chk("sb_beat", m_tdata, dat(2, sb_q.pop_front()));
      end
    end
  end

  initial begin
    int t1, t2, t3, t4, t5, t6;
    rst_n = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 0, 1'b1);

    // single port 0, 3-beat packet
    t1 = vq.size();
    add(1, 4'hF, 4'b0001, 4'h0,    0, 1, 4'h0,    0, 0, 0, 0, 0, 2'd3);
    add(0, 4'hF, 4'b0001, 4'h0,    0, 1, 4'b0001, 0, 0, 0, 0, 1, 2'd0);
    add(0, 4'hF, 4'b0001, 4'h0,    1, 1, 4'b0001, 1, 0, 0, 0, 1, 2'd0);
    add(0, 4'hF, 4'b0001, 4'b0001, 2, 1, 4'b0001, 1, 0, 0, 1, 1, 2'd0);
    add(0, 4'hF, 4'h0,    4'h0,    0, 1, 4'h0,    1, 1, 0, 2, 0, 2'd0);
    add(0, 4'hF, 4'h0,    4'h0,    0, 1, 4'h0,    0, 0, 0, 0, 0, 2'd0);
    // all ports valid, 2-beat packets, round robin 0..3 then back to 0
    t2 = vq.size();
    add(1, 4'hF, 4'hF, 4'h0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 2'd3);
    for (int p = 0; p < NP; p++) begin
      add(0, 4'hF, 4'hF, 4'h0, 0, 1, oh(p), 0, 0, 0, 0, 1, 2'(p));
      add(0, 4'hF, 4'hF, 4'hF, 1, 1, oh(p), 1, 0, p, 0, 1, 2'(p));
      add(0, 4'hF, 4'hF, 4'h0, 0, 1, 4'h0,  1, 1, p, 1, 0, 2'(p));
    end
    add(0, 4'hF, 4'hF, 4'h0, 0, 1, 4'b0001, 0, 0, 0, 0, 1, 2'd0);
    // port 2, 4 beats, output stalls
    t3 = vq.size();
    add(1, 4'hF, 4'b0100, 4'h0,    0, 1, 4'h0,    0, 0, 0, 0, 0, 2'd3);
    add(0, 4'hF, 4'b0100, 4'h0,    0, 1, 4'b0100, 0, 0, 0, 0, 1, 2'd2);
    add(0, 4'hF, 4'b0100, 4'h0,    1, 0, 4'h0,    1, 0, 2, 0, 1, 2'd2);
    add(0, 4'hF, 4'b0100, 4'h0,    1, 0, 4'h0,    1, 0, 2, 0, 1, 2'd2);
    add(0, 4'hF, 4'b0100, 4'h0,    1, 1, 4'b0100, 1, 0, 2, 0, 1, 2'd2);
    add(0, 4'hF, 4'b0100, 4'h0,    2, 1, 4'b0100, 1, 0, 2, 1, 1, 2'd2);
    add(0, 4'hF, 4'b0100, 4'b0100, 3, 0, 4'h0,    1, 0, 2, 2, 1, 2'd2);
    add(0, 4'hF, 4'b0100, 4'b0100, 3, 1, 4'b0100, 1, 0, 2, 2, 1, 2'd2);
    add(0, 4'hF, 4'h0,    4'h0,    0, 1, 4'h0,    1, 1, 2, 3, 0, 2'd2);
    add(0, 4'hF, 4'h0,    4'h0,    0, 1, 4'h0,    0, 0, 0, 0, 0, 2'd2);
    // enable mask 1010, then enable[1] cleared mid-packet
    t4 = vq.size();
    add(1, 4'b1010, 4'hF, 4'h0, 0, 1, 4'h0,    0, 0, 0, 0, 0, 2'd3);
    add(0, 4'b1010, 4'hF, 4'h0, 0, 1, 4'b0010, 0, 0, 0, 0, 1, 2'd1);
    add(0, 4'b1010, 4'hF, 4'hF, 1, 1, 4'b0010, 1, 0, 1, 0, 1, 2'd1);
    add(0, 4'b1010, 4'hF, 4'h0, 0, 1, 4'h0,    1, 1, 1, 1, 0, 2'd1);
    add(0, 4'b1010, 4'hF, 4'h0, 0, 1, 4'b1000, 0, 0, 0, 0, 1, 2'd3);
    add(0, 4'b1010, 4'hF, 4'hF, 1, 1, 4'b1000, 1, 0, 3, 0, 1, 2'd3);
    add(0, 4'b1010, 4'hF, 4'h0, 0, 1, 4'h0,    1, 1, 3, 1, 0, 2'd3);
    add(0, 4'b1000, 4'hF, 4'h0, 0, 1, 4'b0010, 0, 0, 0, 0, 1, 2'd1);
    add(0, 4'b1000, 4'hF, 4'hF, 1, 1, 4'b0010, 1, 0, 1, 0, 1, 2'd1);
    add(0, 4'b1000, 4'hF, 4'h0, 0, 1, 4'h0,    1, 1, 1, 1, 0, 2'd1);
    add(0, 4'b1000, 4'hF, 4'h0, 0, 1, 4'b1000, 0, 0, 0, 0, 1, 2'd3);
    // single-beat packets from ports 0 and 3
    t5 = vq.size();
    add(1, 4'hF, 4'b1001, 4'hF, 0, 1, 4'h0,    0, 0, 0, 0, 0, 2'd3);
    add(0, 4'hF, 4'b1001, 4'hF, 0, 1, 4'b0001, 0, 0, 0, 0, 1, 2'd0);
    add(0, 4'hF, 4'b1001, 4'hF, 0, 1, 4'h0,    1, 1, 0, 0, 0, 2'd0);
    add(0, 4'hF, 4'b1001, 4'hF, 0, 1, 4'b1000, 0, 0, 0, 0, 1, 2'd3);
    add(0, 4'hF, 4'b1001, 4'hF, 0, 1, 4'h0,    1, 1, 3, 0, 0, 2'd3);
    add(0, 4'hF, 4'b1001, 4'hF, 0, 1, 4'b0001, 0, 0, 0, 0, 1, 2'd0);
    t6 = vq.size();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst m_tvalid", DW'(m_tvalid), '0);
    chk("rst m_tdata", m_tdata, '0);
    chk("rst m_tkeep", DW'(m_tkeep), '0);
    chk("rst m_tlast", DW'(m_tlast), '0);
    chk("rst m_conn", DW'(m_conn), '0);
    chk("rst busy", DW'(busy), '0);
    chk("rst s_tready", DW'(s_tready), '0);
    chk("rst grant_idx", DW'(grant_idx), DW'(3));
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_table(t1, t2);
    run_table(t2, t3);
    sb_q  = {0, 1, 2, 3};
    sb_on = 1'b1;
    run_table(t3, t4);
    sb_on = 1'b0;
    chk("sb_leftover", DW'(sb_q.size()), '0);
    run_table(t4, t5);
    run_table(t5, t6);

    // asynchronous reset during beat 2 of a 4-beat packet from port 0
    do_reset();
    drive(4'hF, 4'b0001, 4'h0, 0, 1'b1);
    @(negedge clk);
    chk("ar idle busy", DW'(busy), '0);
    @(posedge clk);
    #1 drive(4'hF, 4'b0001, 4'h0, 0, 1'b1);
    @(negedge clk);
    chk("ar grant s_tready", DW'(s_tready), DW'(4'b0001));
    @(posedge clk);
    #1 drive(4'hF, 4'b0001, 4'h0, 1, 1'b1);
    @(negedge clk);
    chk("ar beat1 m_tvalid", DW'(m_tvalid), DW'(1));
    chk("ar beat1 m_tdata", m_tdata, dat(0, 0));
    #1 rst_n = 1'b0;
    #1;
    chk("ar m_tvalid", DW'(m_tvalid), '0);
    chk("ar s_tready", DW'(s_tready), '0);
    chk("ar busy", DW'(busy), '0);
    chk("ar grant_idx", DW'(grant_idx), DW'(3));
    chk("ar m_tdata", m_tdata, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(4'hF, 4'b1001, 4'h0, 0, 1'b1);
    @(negedge clk);
    chk("ar post idle", DW'(busy), '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ar post grant_idx", DW'(grant_idx), '0);
    chk("ar post s_tready", DW'(s_tready), DW'(4'b0001));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx_stream_arbiter.md
Name: udp_tx_stream_arbiter

Overview:
Packet-level round-robin arbiter that shares the single UDP TX user input of the Ethernet TX engine between NUM_PORTS independent user streams. Once a port wins, the grant is held until that port's tlast beat is accepted, so packets are never interleaved. Each packet carries its connection id to the engine. The block sits directly upstream of the TX engine's udp_tx_axis_* input and has a registered AXI-Stream output stage.

Parameters:
NUM_PORTS, 4, number of requesting user streams (2..16)
DATA_WIDTH, 512, tdata width in bits; tkeep is DATA_WIDTH/8
CONN_ID_WIDTH, 18, connection id width
PORT_IDX_WIDTH, $clog2(NUM_PORTS), localparam, width of a port index

Ports:
tx_axis_aclk  in  1  clock
tx_axis_aresetn  in  1  reset, asynchronous assert, active-low
port_enable  in  NUM_PORTS  per-port enable; a cleared bit blocks new grants to that port
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tready  out  NUM_PORTS  per-port ready
s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  in  NUM_PORTS*DATA_WIDTH/8  per-port tkeep
s_axis_tlast  in  NUM_PORTS  per-port tlast
s_axis_connection_id  in  NUM_PORTS*CONN_ID_WIDTH  per-port connection id, sampled with every beat
m_axis_tvalid  out  1  to the TX engine udp_tx_axis_tvalid
m_axis_tready  in  1  from the TX engine udp_tx_axis_tready
m_axis_tdata  out  DATA_WIDTH  output data
m_axis_tkeep  out  DATA_WIDTH/8  output keep
m_axis_tlast  out  1  output last
m_axis_connection_id  out  CONN_ID_WIDTH  connection id of the current beat
busy  out  1  high while in BUSY
grant_idx  out  PORT_IDX_WIDTH  currently or most recently granted port

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE.
  - m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_connection_id = 0.
  - busy = 0; s_axis_tready = 0.
  - last_grant = NUM_PORTS-1, so port 0 has first priority; grant_idx = NUM_PORTS-1.
  - Reset mid-packet truncates the packet. No recovery is attempted.
- Request definition: req[i] = s_axis_tvalid[i] & port_enable[i].
- IDLE:
  - s_axis_tready = 0.
  - If any req is set: search starts at (last_grant+1) mod NUM_PORTS and wraps; the first set req wins.
  - Register grant_idx = last_grant = winner and go to BUSY. Arbitration costs exactly one cycle.
  - If no req is set: stay in IDLE.
- BUSY:
  - s_axis_tready[grant_idx] = (!m_axis_tvalid | m_axis_tready); all other tready bits are 0.
  - Accept of port g's beat: register its tdata, tkeep, tlast and connection_id into the output stage and set m_axis_tvalid=1.
  - If the output stage is not reloaded and m_axis_tready=1, clear m_axis_tvalid.
  - The accepted tlast beat returns the state to IDLE in the next cycle.
- Throughput and latency:
  - Accept-to-output latency is 1 cycle.
  - Full throughput within a packet: 1 beat/cycle while m_axis_tready is held high.
  - One bubble cycle between packets.
- port_enable:
  - Sampled only at arbitration.
  - Deasserting the granted port's bit mid-packet does NOT abort the packet; the grant holds until tlast.
- Backpressure:
  - m_axis_tvalid=1 with m_axis_tready=0 holds all m_axis_* outputs stable and drops s_axis_tready to 0.
  - Upstream tvalid dropping mid-packet only stalls; the grant is held indefinitely.
- Simultaneous events:
  - The tlast accept and the output drain in the same cycle are both honoured.
  - A request arriving on the cycle the state returns to IDLE is arbitrated in that IDLE cycle.
- Width rules:
  - grant_idx wrap uses modulo NUM_PORTS; a non-power-of-2 NUM_PORTS must never yield an index ≥ NUM_PORTS.
  - A single-beat packet (tlast on the first beat) is legal.
- No data modification: tkeep and tlast pass through unchanged. Length counting is done downstream.

Test Plan:
- Single port: port 0 sends a 3-beat packet, connection id 0x00005, m_tready=1 -> output beats appear 1 cycle after each accept; tlast on beat 3; busy high for 3 cycles plus the drain.
- All 4 ports continuously valid with 2-beat packets -> grant order 0,1,2,3,0,...; never interleaved within a packet; exactly 1 idle cycle between packets.
- Port 2 mid-packet with m_tready toggling 1,0,0,1 -> outputs held stable during stall; s_tready[2] follows the rule; no beat lost or duplicated (compare 4 beats with a scoreboard).
- port_enable=4'b1010 with all ports valid -> only ports 1 and 3 granted, alternating; clearing enable[1] mid-packet still completes port 1's packet.
- Single-beat packets (tlast on the first beat) from ports 0 and 3 back-to-back -> 1-cycle gaps; m_axis_connection_id matches the per-port id.
- Reset asserted during beat 2 of a 4-beat packet -> m_tvalid=0 and s_tready=0 immediately (asynchronous); after release port 0 has priority again.
